// File: rtl/jtcop_obj_pkg.sv
// Shared constants and types for the object line buffer.
// Used by jtcop_obj_buffer and jtcop_obj_linebank.
package jtcop_obj_pkg;

  localparam int BANK_DEPTH = 512;
  localparam int ADDR_W     = 9;
  localparam int PXL_W      = 8;

  localparam logic [3:0]        TRANSP_COLOUR = 4'h0;
  localparam logic [ADDR_W-1:0] SWEEP_LAST    = ADDR_W'(BANK_DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } obj_state_e;

  // Colour index 0 is see-through and never lands in a bank.
  function automatic logic is_opaque(input logic [PXL_W-1:0] pxl);
    return pxl[3:0] != TRANSP_COLOUR;
  endfunction

endpackage

// File: rtl/jtcop_obj_linebank.sv
// One 512x8 object line bank: a write port, a registered read port, and an
// optional clear that zeroes the column one clk after it was read.
module jtcop_obj_linebank
  import jtcop_obj_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PXL_W-1:0]  wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_clr,
  output logic [PXL_W-1:0]  rd_data
);

  logic [PXL_W-1:0]  mem [BANK_DEPTH];
  logic              clr_pend_reg;
  logic [ADDR_W-1:0] clr_addr_reg;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PXL_W-1:0]  mem_din;

  // The owner never writes and clears in the same clk; the mux only shares the port.
  always_comb begin
    mem_we   = we | clr_pend_reg;
    mem_addr = we ? waddr : clr_addr_reg;
    mem_din  = we ? wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_pend_reg <= 1'b0;
      clr_addr_reg <= '0;
    end else begin
      clr_pend_reg <= rd_en & rd_clr;
      clr_addr_reg <= raddr;
    end
  end

endmodule

// File: rtl/jtcop_obj_buffer.sv
// Double-buffered object line buffer with power-up clear sweep and read-clear.
// Define JTCOP_OBJ_FLIP_EN to let the flip input mirror the read column.
module jtcop_obj_buffer
  import jtcop_obj_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic [8:0] hdump,
  input  logic       flip,
  input  logic [8:0] buf_addr,
  input  logic [7:0] buf_data,
  input  logic       buf_we,
  output logic       line_start,
  output logic       init_busy,
  output logic [7:0] obj_pxl
);

  obj_state_e        state_reg;
  logic [ADDR_W-1:0] sweep_n_reg;
  logic              rd_bank_reg;
  logic              lhbl_last_reg;
  logic              line_start_reg;
  logic              init_busy_reg;
  logic [PXL_W-1:0]  obj_pxl_reg;
  logic              rd_valid_reg;
  logic              rd_src_reg;

  logic              in_init;
  logic              rd_fire;
  logic              swap;
  logic              draw_we;
  logic [ADDR_W-1:0] rd_col;
  logic [PXL_W-1:0]  bank_q [2];

`ifdef JTCOP_OBJ_FLIP_EN
  assign rd_col = flip ? ~hdump : hdump;
`else
  wire unused_flip = flip;
  assign rd_col = hdump;
`endif

  assign in_init = (state_reg == ST_INIT);
  assign rd_fire = ~in_init & pxl_cen & LHBL;
  assign swap    = ~in_init & pxl_cen & lhbl_last_reg & ~LHBL;
  assign draw_we = ~in_init & buf_we & is_opaque(buf_data);

  // The front bank is read and cleared; the other bank takes draw writes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic              is_front;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [PXL_W-1:0]  bank_wdata;

    assign is_front   = (rd_bank_reg == 1'(gi));
    assign bank_we    = in_init | (~is_front & draw_we);
    assign bank_waddr = in_init ? sweep_n_reg : buf_addr;
    assign bank_wdata = in_init ? '0 : buf_data;

    jtcop_obj_linebank u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (bank_we),
      .waddr   (bank_waddr),
      .wdata   (bank_wdata),
      .rd_en   (rd_fire & is_front),
      .raddr   (rd_col),
      .rd_clr  (1'b1),
      .rd_data (bank_q[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_INIT;
      sweep_n_reg    <= '0;
      rd_bank_reg    <= 1'b0;
      lhbl_last_reg  <= 1'b1;
      line_start_reg <= 1'b0;
      init_busy_reg  <= 1'b1;
      obj_pxl_reg    <= '0;
      rd_valid_reg   <= 1'b0;
      rd_src_reg     <= 1'b0;
    end else begin
      line_start_reg <= swap;
      if (pxl_cen) lhbl_last_reg <= LHBL;
      case (state_reg)
        ST_INIT: begin
          sweep_n_reg  <= sweep_n_reg + ADDR_W'(1);
          obj_pxl_reg  <= '0;
          rd_valid_reg <= 1'b0;
          if (sweep_n_reg == SWEEP_LAST) begin
            state_reg     <= ST_RUN;
            init_busy_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          if (swap) rd_bank_reg <= ~rd_bank_reg;
          // Data read on the previous enable is shown now; blanking forces 0.
          if (pxl_cen) begin
            obj_pxl_reg  <= (LHBL && rd_valid_reg) ? bank_q[rd_src_reg] : '0;
            rd_valid_reg <= LHBL;
            rd_src_reg   <= rd_bank_reg;
          end
        end
      endcase
    end
  end

  assign line_start = line_start_reg;
  assign init_busy  = init_busy_reg;
  assign obj_pxl    = obj_pxl_reg;

endmodule

// File: tb/tb_jtcop_obj_buffer.sv
// Directed and randomized bench for jtcop_obj_buffer with a line-level model.
// Follows JTCOP_OBJ_FLIP_EN when computing expected read columns.
module tb_jtcop_obj_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b1;
  logic [8:0] hdump = '0;
  logic       flip = 1'b0;
  logic [8:0] buf_addr = '0;
  logic [7:0] buf_data = '0;
  logic       buf_we = 1'b0;
  logic       line_start;
  logic       init_busy;
  logic [7:0] obj_pxl;

  int tests = 0;
  int fails = 0;

  // Model: two line memories, which one is on screen, and the pixel in flight.
  logic [7:0] m_mem [2][512];
  int         m_front;
  logic [7:0] m_pend;
  bit         m_pend_v;
  bit         m_lhbl_last;
  logic [7:0] m_last;

  jtcop_obj_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .pxl_cen    (pxl_cen),
    .LHBL       (LHBL),
    .hdump      (hdump),
    .flip       (flip),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .buf_we     (buf_we),
    .line_start (line_start),
    .init_busy  (init_busy),
    .obj_pxl    (obj_pxl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) m_mem[b][a] = 8'h00;
    m_front = 0; m_pend_v = 0; m_pend = 8'h00; m_lhbl_last = 1; m_last = 8'h00;
  endtask

  function automatic logic [8:0] model_col(input logic [8:0] hd);
`ifdef JTCOP_OBJ_FLIP_EN
    return flip ? 9'(511 - int'(hd)) : hd;
`else
    return hd;
`endif
  endfunction

  task automatic model_write(input logic we, input logic [8:0] a, input logic [7:0] d);
    if (we && d[3:0] != 4'h0) m_mem[1 - m_front][a] = d;
  endtask

  // One pixel-enable clk, optionally carrying a draw write.
  task automatic do_cen(input logic lhbl, input logic [8:0] hd, input logic we,
                        input logic [8:0] a, input logic [7:0] d);
    logic [7:0] exp_pxl;
    logic       exp_ls;
    logic [8:0] col;
    exp_ls = m_lhbl_last && !lhbl;
    model_write(we, a, d);
    if (lhbl) begin
      exp_pxl = m_pend_v ? m_pend : 8'h00;
      col = model_col(hd);
      m_pend = m_mem[m_front][col];
      m_mem[m_front][col] = 8'h00;
      m_pend_v = 1;
    end else begin
      exp_pxl = 8'h00;
      m_pend_v = 0;
    end
    m_lhbl_last = lhbl;
    if (exp_ls) m_front = 1 - m_front;
    m_last = exp_pxl;
    pxl_cen = 1'b1; LHBL = lhbl; hdump = hd; buf_we = we; buf_addr = a; buf_data = d;
    tick();
    pxl_cen = 1'b0; buf_we = 1'b0;
    check($sformatf("obj_pxl hdump=%0h", hd), 16'(obj_pxl), 16'(exp_pxl));
    check($sformatf("line_start hdump=%0h", hd), 16'(line_start), 16'(exp_ls));
  endtask

  // A clk without pixel enable: output must hold, no line_start.
  task automatic do_idle(input logic we, input logic [8:0] a, input logic [7:0] d);
    model_write(we, a, d);
    buf_we = we; buf_addr = a; buf_data = d;
    tick();
    buf_we = 1'b0;
    check("obj_pxl hold", 16'(obj_pxl), 16'(m_last));
    check("line_start idle", 16'(line_start), 16'h0);
  endtask

  task automatic show_line(input int start, input int n, input bit gaps, input bit wr);
    do_cen(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    do_cen(1'b0, 9'h0, 1'b0, 9'h0, 8'h0);
    for (int i = 0; i < n; i++) begin
      do_cen(1'b1, 9'(start + i), wr && ($urandom_range(0, 3) == 0),
             9'($urandom), 8'($urandom));
      if (gaps)
        repeat ($urandom_range(0, 2)) do_idle(wr && ($urandom_range(0, 1) == 0),
                                               9'($urandom), 8'($urandom));
    end
  endtask

  // Sweep with hostile inputs toggling; it must take 512 clks and ignore them.
  task automatic run_init(input string tag);
    int cnt;
    bit ls_seen;
    bit obj_nz;
    cnt = 0; ls_seen = 0; obj_nz = 0;
    while (init_busy === 1'b1 && cnt < 2000) begin
      pxl_cen = cnt[0]; LHBL = (cnt % 8) < 4; hdump = 9'(cnt);
      buf_we = 1'b1; buf_addr = 9'($urandom); buf_data = 8'hFF;
      tick();
      cnt++;
      if (line_start !== 1'b0) ls_seen = 1;
      if (obj_pxl !== 8'h00) obj_nz = 1;
    end
    pxl_cen = 1'b0; buf_we = 1'b0; LHBL = 1'b1;
    check({tag, " busy clks"}, 16'(cnt), 16'd512);
    check({tag, " line_start in init"}, 16'(ls_seen), 16'h0);
    check({tag, " obj_pxl in init"}, 16'(obj_nz), 16'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    check("reset init_busy", 16'(init_busy), 16'h1);
    check("reset obj_pxl", 16'(obj_pxl), 16'h0);
    check("reset line_start", 16'(line_start), 16'h0);

    rst = 1'b0;
    run_init("init");
    do_cen(1'b1, 9'h0, 1'b0, 9'h0, 8'h0);

    // Both banks empty after the sweep; hdump wraps past 511.
    show_line(0, 513, 1'b0, 1'b0);
    show_line(0, 513, 1'b0, 1'b0);

    // Opaque pixel shows, transparent one does not.
    do_idle(1'b1, 9'd10, 8'h5A);
    do_idle(1'b1, 9'd11, 8'h30);
    show_line(8, 8, 1'b1, 1'b0);

    // Last write wins; the bank is empty again the next time it is shown.
    do_idle(1'b1, 9'd100, 8'h13);
    do_idle(1'b1, 9'd100, 8'h27);
    show_line(98, 6, 1'b1, 1'b0);
    show_line(0, 4, 1'b0, 1'b0);
    show_line(98, 6, 1'b1, 1'b0);

    // Mirrored read column.
    flip = 1'b1;
    do_idle(1'b1, 9'h1F0, 8'h4F);
    show_line(9'h00D, 5, 1'b0, 1'b0);
    show_line(9'h1EE, 5, 1'b0, 1'b0);
    flip = 1'b0;

    // Write in the swap clk vs. one clk later.
    do_cen(1'b1, 9'd5, 1'b0, 9'h0, 8'h0);
    do_cen(1'b0, 9'd0, 1'b1, 9'd200, 8'hA7);
    do_idle(1'b1, 9'd201, 8'hB3);
    do_cen(1'b0, 9'd0, 1'b0, 9'h0, 8'h0);
    for (int i = 198; i < 204; i++) do_cen(1'b1, 9'(i), 1'b0, 9'h0, 8'h0);
    show_line(198, 6, 1'b0, 1'b0);

    // Randomized lines with concurrent drawing.
    for (int l = 0; l < 4; l++) begin
      flip = 1'($urandom);
      for (int w = 0; w < 60; w++) do_idle(1'b1, 9'($urandom), 8'($urandom));
      show_line(int'($urandom_range(0, 511)), 512, 1'b1, 1'b1);
    end
    flip = 1'b0;

    // Reset in the middle of the sweep restarts it.
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    repeat (300) tick();
    check("mid-sweep init_busy", 16'(init_busy), 16'h1);
    rst = 1'b1; tick();
    check("re-reset obj_pxl", 16'(obj_pxl), 16'h0);
    rst = 1'b0;
    model_reset();
    run_init("restart");
    do_cen(1'b1, 9'h0, 1'b0, 9'h0, 8'h0);
    show_line(0, 16, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtcop_obj_buffer.md
JTCOP_OBJ_BUFFER -- requirements
Module: jtcop_obj_buffer

Interface
REQ-001 clk  in  1  pixel-domain clock; all logic rises on it.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 pxl_cen  in  1  pixel clock enable.
REQ-004 LHBL  in  1  horizontal blank, active-low.
REQ-005 hdump  in  9  current screen column being read out.
REQ-006 flip  in  1  screen flip; mirrors read column.
REQ-007 buf_addr  in  9  draw-engine write column.
REQ-008 buf_data  in  8  draw-engine pixel: {palette[7:4], colour[3:0]}.
REQ-009 buf_we  in  1  draw-engine write strobe, one pixel per clk.
REQ-010 line_start  out  1  one-clk pulse: back bank empty and ready for the next line.
REQ-011 init_busy  out  1  high while the power-up clear sweep runs.
REQ-012 obj_pxl  out  8  object pixel for colour mixer (MCOL).

Function
REQ-013 Two 512x8 line banks; rd_bank selects the front (read) bank; the other is the back (draw) bank.
REQ-014 Swap: on the pxl_cen where LHBL samples 1->0, rd_bank toggles and line_start pulses on the following clk.
REQ-015 Writes with buf_we=1 go to back bank at buf_addr; buf_data[3:0]==0 is transparent and is not written.
REQ-016 Non-transparent writes overwrite unconditionally; the last write to a column wins.
REQ-017 Read: on each pxl_cen with LHBL=1, front bank is read at col = flip ? ~hdump : hdump.
REQ-018 obj_pxl updates on the pxl_cen after the address is presented (1 pxl_cen latency) and holds between enables.
REQ-019 Read-clear: the clk after each read, the same front-bank column is written 0; line reads leave the bank empty.
REQ-020 During LHBL=0 no reads or clears; obj_pxl is 0.
REQ-021 Draw writes and clears never collide: they target different banks by construction.
REQ-022 A write in the same clk as a swap lands in the pre-swap back bank; later writes go to the new back bank.
REQ-023 hdump wraps 511->0 with no special handling.
REQ-024 FSM states: INIT (sweep), RUN. INIT writes 0 to address n of both banks, n=0..511, one per clk; after n=511 it moves to RUN.
REQ-025 In INIT: init_busy=1, buf_we ignored, obj_pxl=0, line_start held 0, swaps not acted on.

Reset
REQ-026 rst=1: state=INIT, n=0, rd_bank=0, obj_pxl=0, line_start=0, init_busy=1, edge detector LHBL history=1.
REQ-027 rst asserted mid-line or mid-sweep restarts the sweep from n=0; bank contents are not trusted until RUN.
REQ-028 RUN is entered exactly 512 clk after rst deasserts.

Configuration
REQ-029 Macro JTCOP_OBJ_FLIP_EN: when defined, flip applies per REQ-017; when undefined, flip is ignored (col=hdump) and the port remains.

Structure
REQ-030 Shared package jtcop_obj_pkg holds the bank depth (512), address width (9), pixel width (8), the transparency mask (4'h0), and the FSM state enum.
REQ-031 One sub-module, jtcop_obj_linebank: a single 512x8 bank with a write port, read port and read-clear; instantiated twice.

Verification
REQ-032 Release rst -> init_busy high 512 clk then low; every address of both banks reads 0; line_start stays 0 throughout.
REQ-033 Write 0x5A at col 10 and 0x30 at col 11, then swap -> read hdump=10 gives 0x5A one pxl_cen later; col 11 gives 0x00 because it is transparent.
REQ-034 Write 0x13 then 0x27 to col 100, then swap -> 0x27; the next line on the same bank reads col 100 as 0x00 (read-clear).
REQ-035 With the macro defined: flip=1, value 0x4F at col 0x1F0, hdump=0x00F -> 0x4F. Without the macro, the same stimulus -> 0x00.
REQ-036 buf_we in the same clk as the LHBL-fall swap -> that pixel appears on the line displayed next; a write one clk later appears a line after that.
REQ-037 Assert rst at sweep n=300 -> sweep restarts; init_busy low exactly 512 clk after release.
